// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - ICache/DCache line-burst arbiter onto one memory port (optional macro: ARB_D_PRIORITY_EN)
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_rd_req,
    input  logic [ADDR_W-1:0]           i_rd_addr,
    output logic                        i_rd_gnt,
    input  logic                        i_cancel,
    output logic [DATA_W-1:0]           i_rdata,
    output logic                        i_rvalid,
    output logic                        i_rlast,
    input  logic                        d_rd_req,
    input  logic [ADDR_W-1:0]           d_rd_addr,
    output logic                        d_rd_gnt,
    output logic [DATA_W-1:0]           d_rdata,
    output logic                        d_rvalid,
    output logic                        d_rlast,
    input  logic                        d_wr_req,
    input  logic [ADDR_W-1:0]           d_wr_addr,
    input  logic [BURST_LEN*DATA_W-1:0] d_wr_line,
    output logic                        d_wr_gnt,
    output logic                        d_wr_done,
    output logic                        m_req,
    output logic                        m_we,
    output logic [ADDR_W-1:0]           m_addr,
    input  logic                        m_ack,
    output logic [DATA_W-1:0]           m_wdata,
    output logic                        m_wvalid,
    output logic                        m_wlast,
    input  logic                        m_wready,
    input  logic [DATA_W-1:0]           m_rdata,
    input  logic                        m_rvalid,
    input  logic                        m_bvalid
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP
    } state_t;

    localparam int               CNT_W    = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t              state_q;
    logic                owner_d_q;     // 1 = DCache owns the current burst
    logic                last_d_q;      // 1 = DCache won the previous arbitration
    logic [CNT_W-1:0]    cnt_q;
    logic                drop_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                i_gnt_q;
    logic                dr_gnt_q;
    logic                dw_gnt_q;

    logic                d_any_d;
    logic                any_req_d;
    logic                pick_d_d;
    logic                cancel_hit_d;
    logic                rd_phase_d;

    // Arbitration decision: D-write beats D-read inside D; I vs D by round-robin or fixed D priority
    always_comb begin
        d_any_d      = d_wr_req | d_rd_req;
        any_req_d    = d_any_d | i_rd_req;
`ifdef ARB_D_PRIORITY_EN
        pick_d_d     = d_any_d;
`else
        pick_d_d     = d_any_d & (~i_rd_req | ~last_d_q);
`endif
        cancel_hit_d = i_cancel & ~owner_d_q;
    end

    // Burst sequencer: grant, address phase, data phase, write response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_d_q <= 1'b0;
            last_d_q  <= 1'b1;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
            addr_q    <= '0;
            i_gnt_q   <= 1'b0;
            dr_gnt_q  <= 1'b0;
            dw_gnt_q  <= 1'b0;
        end else begin
            i_gnt_q  <= 1'b0;
            dr_gnt_q <= 1'b0;
            dw_gnt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (any_req_d) begin
                        owner_d_q <= pick_d_d;
                        last_d_q  <= pick_d_d;
                        cnt_q     <= '0;
                        if (pick_d_d && d_wr_req) begin
                            addr_q   <= d_wr_addr;
                            state_q  <= WR_ADDR;
                            dw_gnt_q <= 1'b1;
                        end else if (pick_d_d) begin
                            addr_q   <= d_rd_addr;
                            state_q  <= RD_ADDR;
                            dr_gnt_q <= 1'b1;
                        end else begin
                            addr_q   <= i_rd_addr;
                            state_q  <= RD_ADDR;
                            i_gnt_q  <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (cancel_hit_d) drop_q <= 1'b1;
                    if (m_ack) begin
                        state_q <= RD_DATA;
                        cnt_q   <= '0;
                    end
                end
                RD_DATA: begin
                    if (cancel_hit_d) drop_q <= 1'b1;
                    if (m_rvalid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE;
                            drop_q  <= 1'b0;
                        end
                    end
                end
                WR_ADDR: begin
                    if (m_ack) begin
                        state_q <= WR_DATA;
                        cnt_q   <= '0;
                    end
                end
                WR_DATA: begin
                    if (m_wready) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) state_q <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_bvalid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output decode; read data routed combinationally to the owning cache only
    always_comb begin
        rd_phase_d = (state_q == RD_DATA);
        i_rd_gnt   = i_gnt_q;
        d_rd_gnt   = dr_gnt_q;
        d_wr_gnt   = dw_gnt_q;
        m_req      = (state_q == RD_ADDR) || (state_q == WR_ADDR);
        m_we       = (state_q == WR_ADDR);
        m_addr     = m_req ? addr_q : '0;
        i_rdata    = (rd_phase_d && !owner_d_q) ? m_rdata : '0;
        i_rvalid   = rd_phase_d && !owner_d_q && m_rvalid && !drop_q && !i_cancel;
        i_rlast    = i_rvalid && (cnt_q == CNT_LAST);
        d_rdata    = (rd_phase_d && owner_d_q) ? m_rdata : '0;
        d_rvalid   = rd_phase_d && owner_d_q && m_rvalid;
        d_rlast    = d_rvalid && (cnt_q == CNT_LAST);
        m_wvalid   = (state_q == WR_DATA);
        m_wdata    = m_wvalid ? d_wr_line[int'(cnt_q)*DATA_W +: DATA_W] : '0;
        m_wlast    = m_wvalid && (cnt_q == CNT_LAST);
        d_wr_done  = (state_q == WR_RESP) && m_bvalid;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic rst;
    logic i_rd_req, i_rd_gnt, i_cancel, i_rvalid, i_rlast;
    logic [AW-1:0] i_rd_addr;
    logic [DW-1:0] i_rdata;
    logic d_rd_req, d_rd_gnt, d_rvalid, d_rlast;
    logic [AW-1:0] d_rd_addr;
    logic [DW-1:0] d_rdata;
    logic d_wr_req, d_wr_gnt, d_wr_done;
    logic [AW-1:0] d_wr_addr;
    logic [BL*DW-1:0] d_wr_line;
    logic m_req, m_we, m_ack, m_wvalid, m_wlast, m_wready, m_rvalid, m_bvalid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_gnt(i_rd_gnt), .i_cancel(i_cancel),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
        .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_gnt(d_rd_gnt),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_line(d_wr_line),
        .d_wr_gnt(d_wr_gnt), .d_wr_done(d_wr_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_ack(m_ack),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_bvalid(m_bvalid)
    );

    logic [159:0] all_out;
    assign all_out = {i_rd_gnt, i_rdata, i_rvalid, i_rlast, d_rd_gnt, d_rdata, d_rvalid, d_rlast,
                      d_wr_gnt, d_wr_done, m_req, m_we, m_addr, m_wdata, m_wvalid, m_wlast};

    localparam logic [2:0] G_I = 3'b100, G_DW = 3'b010, G_DR = 3'b001;

    int total = 0;
    int bad = 0;
    logic [2:0]  exp_gnt[$];
    logic [32:0] exp_addr[$];
    logic [32:0] exp_i[$];
    logic [32:0] exp_d[$];
    logic [32:0] exp_w[$];
    logic        exp_done[$];
    logic [31:0] rd_beats[$];
    int pend_i = 0, pend_dr = 0, pend_dw = 0;
    int ack_dly = 0, stall_beat = -1, stall_n = 0, cancel_beat = -1;
    int cur_beat = -1;
    int bus_rbeats = 0;
    bit bus_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cache-side requesters: hold req while requests remain, count down on each grant
    initial begin
        i_rd_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0;
        forever begin
            tick();
            if (i_rd_gnt) pend_i--;
            if (d_rd_gnt) pend_dr--;
            if (d_wr_gnt) pend_dw--;
            i_rd_req = (pend_i > 0);
            d_rd_req = (pend_dr > 0);
            d_wr_req = (pend_dw > 0);
        end
    end

    // Memory-side model: acks after ack_dly, streams rd_beats, stalls writes, answers bvalid
    initial begin : bus
        logic we;
        m_ack = 1'b0; m_rdata = '0; m_rvalid = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; i_cancel = 1'b0;
        forever begin
            tick();
            if (m_req && !rst) begin
                bus_busy = 1'b1;
                we = m_we;
                for (int k = 0; k < ack_dly; k++) tick();
                m_ack = 1'b1;
                tick();
                m_ack = 1'b0;
                if (!we) begin
                    for (int b = 0; b < BL && !rst; b++) begin
                        cur_beat = b;
                        m_rdata  = (rd_beats.size() > 0) ? rd_beats.pop_front() : 32'hDEAD_BEEF;
                        m_rvalid = 1'b1;
                        i_cancel = (b == cancel_beat);
                        tick();
                    end
                    m_rvalid = 1'b0; m_rdata = '0; i_cancel = 1'b0; cur_beat = -1;
                end else begin
                    for (int b = 0; b < BL; b++) begin
                        if (b == stall_beat) begin
                            m_wready = 1'b0;
                            repeat (stall_n) tick();
                        end
                        m_wready = 1'b1;
                        tick();
                    end
                    m_wready = 1'b0;
                    m_bvalid = 1'b1;
                    tick();
                    m_bvalid = 1'b0;
                end
                bus_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a grant, address, beat or response
    always @(negedge clk) begin
        if (!rst) begin
            if (m_rvalid) bus_rbeats++;
            if (i_rd_gnt || d_rd_gnt || d_wr_gnt) begin
                if (exp_gnt.size() == 0) chk("gnt_unexpected", {i_rd_gnt, d_wr_gnt, d_rd_gnt}, 3'b000);
                else chk("gnt_order", {i_rd_gnt, d_wr_gnt, d_rd_gnt}, exp_gnt.pop_front());
            end
            if (m_req && m_ack) begin
                if (exp_addr.size() == 0) chk("addr_unexpected", m_req, 1'b0);
                else chk("addr_phase", {m_we, m_addr}, exp_addr.pop_front());
            end
            if (i_rvalid) begin
                if (exp_i.size() == 0) chk("i_rvalid_unexpected", i_rvalid, 1'b0);
                else chk("i_beat", {i_rlast, i_rdata}, exp_i.pop_front());
            end
            if (d_rvalid) begin
                if (exp_d.size() == 0) chk("d_rvalid_unexpected", d_rvalid, 1'b0);
                else chk("d_beat", {d_rlast, d_rdata}, exp_d.pop_front());
            end
            if (m_wvalid) begin
                if (exp_w.size() == 0) chk("wvalid_unexpected", m_wvalid, 1'b0);
                else if (m_wready) chk("w_beat", {m_wlast, m_wdata}, exp_w.pop_front());
                else chk("w_stall_hold", {m_wlast, m_wdata}, exp_w[0]);
            end
            if (d_wr_done) begin
                if (exp_done.size() == 0) chk("wr_done_unexpected", d_wr_done, 1'b0);
                else chk("wr_done", d_wr_done, exp_done.pop_front());
            end
        end
    end

    task automatic push_beat(input bit to_d, input logic [31:0] data, input bit last, input bit expect_it);
        rd_beats.push_back(data);
        if (expect_it) begin
            if (to_d) exp_d.push_back({last, data});
            else      exp_i.push_back({last, data});
        end
    endtask

    task automatic push_burst(input bit to_d, input logic [31:0] base);
        for (int b = 0; b < BL; b++) push_beat(to_d, base + 32'(b), (b == BL - 1), 1'b1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        int left;
        left = 1;
        while (left != 0 && n < 2000) begin
            @(negedge clk);
            n++;
            left = exp_gnt.size() + exp_addr.size() + exp_i.size() + exp_d.size() + exp_w.size()
                 + exp_done.size() + pend_i + pend_dr + pend_dw + int'(bus_busy);
        end
        chk({name, "_pending_left"}, left, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        exp_gnt.delete(); exp_addr.delete(); exp_i.delete(); exp_d.delete();
        exp_w.delete(); exp_done.delete(); rd_beats.delete();
        pend_i = 0; pend_dr = 0; pend_dw = 0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        i_rd_addr = '0; d_rd_addr = '0; d_wr_addr = '0; d_wr_line = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_idle", |all_out, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of an I read burst
        i_rd_addr = 32'h1000_0000;
        exp_gnt.push_back(G_I);
        exp_addr.push_back({1'b0, 32'h1000_0000});
        push_beat(1'b0, 32'hB0, 1'b0, 1'b1);
        push_beat(1'b0, 32'hB1, 1'b0, 1'b1);
        push_beat(1'b0, 32'hB2, 1'b0, 1'b0);
        push_beat(1'b0, 32'hB3, 1'b1, 1'b0);
        pend_i = 1;
        n = 0;
        while (cur_beat != 2 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("reached_beat2", cur_beat, 2);
        rst = 1'b1;
        #1;
        chk("reset_outputs_midburst", |all_out, 1'b0);
        chk("beats_before_reset", exp_i.size(), 0);
        do_reset();

        // I/D tie after reset: I first
        i_rd_addr = 32'h2000_0000; d_rd_addr = 32'h3000_0000;
        exp_gnt.push_back(G_I); exp_gnt.push_back(G_DR);
        exp_addr.push_back({1'b0, 32'h2000_0000}); exp_addr.push_back({1'b0, 32'h3000_0000});
        push_burst(1'b0, 32'hC0); push_burst(1'b1, 32'hD0);
        pend_i = 1; pend_dr = 1;
        drain("tie_after_reset");

        // I refill with a slow address ack
        ack_dly = 2;
        i_rd_addr = 32'h1C00_0000;
        exp_gnt.push_back(G_I);
        exp_addr.push_back({1'b0, 32'h1C00_0000});
        push_beat(1'b0, 32'h11, 1'b0, 1'b1);
        push_beat(1'b0, 32'h22, 1'b0, 1'b1);
        push_beat(1'b0, 32'h33, 1'b0, 1'b1);
        push_beat(1'b0, 32'h44, 1'b1, 1'b1);
        pend_i = 1;
        drain("i_refill");
        ack_dly = 0;

        // Both held continuously; last winner was I, so D,I,D,I
        i_rd_addr = 32'h5000_0000; d_rd_addr = 32'h6000_0000;
        for (int k = 0; k < 4; k++) begin
            exp_gnt.push_back((k % 2 == 0) ? G_DR : G_I);
            exp_addr.push_back({1'b0, (k % 2 == 0) ? 32'h6000_0000 : 32'h5000_0000});
            push_burst(k % 2 == 0, 32'(k + 1) << 8);
        end
        pend_i = 2; pend_dr = 2;
        drain("round_robin");

        // From reset: I, D-write (stalled beat 1), D-read
        do_reset();
        i_rd_addr = 32'h7000_0000; d_wr_addr = 32'h4000_0040; d_rd_addr = 32'h8000_0000;
        d_wr_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        stall_beat = 1; stall_n = 3;
        exp_gnt.push_back(G_I); exp_gnt.push_back(G_DW); exp_gnt.push_back(G_DR);
        exp_addr.push_back({1'b0, 32'h7000_0000});
        exp_addr.push_back({1'b1, 32'h4000_0040});
        exp_addr.push_back({1'b0, 32'h8000_0000});
        push_burst(1'b0, 32'hE0); push_burst(1'b1, 32'hF0);
        exp_w.push_back({1'b0, 32'hA0}); exp_w.push_back({1'b0, 32'hA1});
        exp_w.push_back({1'b0, 32'hA2}); exp_w.push_back({1'b1, 32'hA3});
        exp_done.push_back(1'b1);
        pend_i = 1; pend_dw = 1; pend_dr = 1;
        drain("three_way");
        stall_beat = -1;

        // Cancel on beat 2 of an I burst; cancel also pulses during the following D burst
        cancel_beat = 2;
        bus_rbeats = 0;
        i_rd_addr = 32'h9000_0000; d_rd_addr = 32'hA000_0000;
        exp_gnt.push_back(G_I); exp_gnt.push_back(G_DR);
        exp_addr.push_back({1'b0, 32'h9000_0000}); exp_addr.push_back({1'b0, 32'hA000_0000});
        push_beat(1'b0, 32'h60, 1'b0, 1'b1);
        push_beat(1'b0, 32'h61, 1'b0, 1'b1);
        push_beat(1'b0, 32'h62, 1'b0, 1'b0);
        push_beat(1'b0, 32'h63, 1'b1, 1'b0);
        push_burst(1'b1, 32'h70);
        pend_i = 1;
        n = 0;
        while (pend_i != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cancel_i_granted", pend_i, 0);
        pend_dr = 1;
        drain("cancel");
        chk("cancel_bus_beats", bus_rbeats, 8);
        chk("rd_beats_consumed", rd_beats.size(), 0);
        cancel_beat = -1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
